ysyx_23060124_wbu_commit: RTL and testbench

Write-back/commit stage sitting on the receiving side of the EXU→WBU pipeline registers. It accepts one executed instruction per handshake and writes the integer register file. It also owns and updates the machine CSRs (mstatus, mtvec, mepc, mcause) and resolves the next PC, covering sequential, branch, jal, jalr, ecall and mret. The next PC is handed back to the IFU over a valid/ready handshake, and a retire pulse is emitted for the difftest/perf hooks.

---
 rtl/ysyx_23060124_wbu_commit.sv | 178 +++++++++++++++++
 tb/tb_ysyx_23060124_wbu_commit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_wbu_commit.sv
// WBU commit stage: latches one EXU result, writes GPR/CSRs,
// resolves next PC and hands it to the IFU, pulses retire.
// Ports: i_valid/o_ready EXU handshake; i_* instruction bundle;
// i_csr_raddr/o_csr_rdata CSR read; o_rf_* GPR write;
// o_npc_valid/i_npc_ready/o_npc IFU handshake; o_retire.
module ysyx_23060124_wbu_commit (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_next,
  input  logic [31:0] i_res,
  input  logic [4:0]  i_rd_addr,
  input  logic [11:0] i_csr_addr,
  input  logic        i_wen,
  input  logic        i_csr_wen,
  input  logic        i_brch,
  input  logic        i_jal,
  input  logic        i_jalr,
  input  logic        i_mret,
  input  logic        i_ecall,
  input  logic [11:0] i_csr_raddr,
  output logic [31:0] o_csr_rdata,
  output logic        o_rf_wen,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_npc_valid,
  input  logic        i_npc_ready,
  output logic [31:0] o_npc,
  output logic        o_retire
);

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMMIT,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [31:0] pc_q, pc_next_q, res_q;
  logic [4:0]  rd_q;
  logic [11:0] csr_addr_q;
  logic        wen_q, csr_wen_q, brch_q;
  logic        jal_q, jalr_q, mret_q, ecall_q;

  logic [31:0] mstatus, mtvec, mepc, mcause;
  logic [31:0] npc_q, npc_c, pc4, csr_old;

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    o_ready     = 1'b0;
    o_npc_valid = 1'b0;
    o_rf_wen    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        o_npc_valid = 1'b1;
        o_rf_wen    = wen_q && (rd_q != 5'd0);
        state_d     = i_npc_ready ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        o_npc_valid = 1'b1;
        if (i_npc_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    csr_old = 32'd0;
    unique case (csr_addr_q)
      MSTATUS: csr_old = mstatus;
      MTVEC:   csr_old = mtvec;
      MEPC:    csr_old = mepc;
      MCAUSE:  csr_old = mcause;
      default: csr_old = 32'd0;
    endcase
  end

  always_comb begin
    o_csr_rdata = 32'd0;
    unique case (i_csr_raddr)
      MSTATUS: o_csr_rdata = mstatus;
      MTVEC:   o_csr_rdata = mtvec;
      MEPC:    o_csr_rdata = mepc;
      MCAUSE:  o_csr_rdata = mcause;
      default: o_csr_rdata = 32'd0;
    endcase
  end

  // Control-flow classes may overlap; this order is the priority.
  always_comb begin
    npc_c = pc4;
    if (ecall_q)                npc_c = mtvec;
    else if (mret_q)            npc_c = mepc;
    else if (jalr_q)            npc_c = res_q & ~32'd1;
    else if (jal_q || brch_q)   npc_c = pc_next_q;
  end

  always_comb begin
    o_rf_wdata = res_q;
    if (jal_q || jalr_q)  o_rf_wdata = pc4;
    else if (csr_wen_q)   o_rf_wdata = csr_old;
  end

  assign o_rf_waddr = rd_q;
  // CSRs may change at the end of COMMIT, so WAIT replays the
  // registered copy to keep the PC stable.
  assign o_npc      = (state_q == S_COMMIT) ? npc_c : npc_q;
  assign o_retire   = o_npc_valid && i_npc_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= 32'd0;
      pc_next_q  <= 32'd0;
      res_q      <= 32'd0;
      rd_q       <= 5'd0;
      csr_addr_q <= 12'd0;
      wen_q      <= 1'b0;
      csr_wen_q  <= 1'b0;
      brch_q     <= 1'b0;
      jal_q      <= 1'b0;
      jalr_q     <= 1'b0;
      mret_q     <= 1'b0;
      ecall_q    <= 1'b0;
      npc_q      <= 32'd0;
      mstatus    <= 32'h0000_1800;
      mtvec      <= 32'd0;
      mepc       <= 32'd0;
      mcause     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && i_valid) begin
        pc_q       <= i_pc;
        pc_next_q  <= i_pc_next;
        res_q      <= i_res;
        rd_q       <= i_rd_addr;
        csr_addr_q <= i_csr_addr;
        wen_q      <= i_wen;
        csr_wen_q  <= i_csr_wen;
        brch_q     <= i_brch;
        jal_q      <= i_jal;
        jalr_q     <= i_jalr;
        mret_q     <= i_mret;
        ecall_q    <= i_ecall;
      end
      if (state_q == S_COMMIT) begin
        npc_q <= npc_c;
        if (ecall_q) begin
          mepc   <= pc_q;
          mcause <= 32'd11;
        end else if (csr_wen_q) begin
          unique case (csr_addr_q)
            MSTATUS: mstatus <= res_q;
            MTVEC:   mtvec   <= res_q;
            MEPC:    mepc    <= res_q;
            MCAUSE:  mcause  <= res_q;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_wbu_commit.sv
// Bench for ysyx_23060124_wbu_commit: directed table,
// hand-written reset/stall sequences, random vs model.
module tb_ysyx_23060124_wbu_commit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_pc = '0, i_pc_next = '0, i_res = '0;
  logic [4:0]  i_rd_addr = '0;
  logic [11:0] i_csr_addr = '0;
  logic        i_wen = 0, i_csr_wen = 0, i_brch = 0;
  logic        i_jal = 0, i_jalr = 0, i_mret = 0, i_ecall = 0;
  logic [11:0] i_csr_raddr = '0;
  logic [31:0] o_csr_rdata;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_npc_valid;
  logic        i_npc_ready = 1'b0;
  logic [31:0] o_npc;
  logic        o_retire;

  ysyx_23060124_wbu_commit dut (
    .clock(clock), .reset(reset),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_pc_next(i_pc_next), .i_res(i_res),
    .i_rd_addr(i_rd_addr), .i_csr_addr(i_csr_addr),
    .i_wen(i_wen), .i_csr_wen(i_csr_wen), .i_brch(i_brch),
    .i_jal(i_jal), .i_jalr(i_jalr), .i_mret(i_mret),
    .i_ecall(i_ecall), .i_csr_raddr(i_csr_raddr),
    .o_csr_rdata(o_csr_rdata), .o_rf_wen(o_rf_wen),
    .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_npc_valid(o_npc_valid), .i_npc_ready(i_npc_ready),
    .o_npc(o_npc), .o_retire(o_retire)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc, pc_next, res;
    logic [4:0]  rd;
    logic [11:0] ca;
    logic [6:0]  fl;
  } instr_t;

  typedef struct {
    instr_t      in;
    int          stall;
    logic [31:0] npc;
    logic        wen;
    logic [31:0] wdata;
  } vec_t;

  localparam logic [6:0] W  = 7'b1000000;
  localparam logic [6:0] C  = 7'b0100000;
  localparam logic [6:0] B  = 7'b0010000;
  localparam logic [6:0] J  = 7'b0001000;
  localparam logic [6:0] JR = 7'b0000100;
  localparam logic [6:0] M  = 7'b0000010;
  localparam logic [6:0] E  = 7'b0000001;

  int total = 0;
  int passed = 0;

  logic [31:0] csr_m [int];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  function automatic instr_t mk(logic [31:0] pc, logic [31:0] pn,
      logic [31:0] res, logic [4:0] rd, logic [11:0] ca,
      logic [6:0] fl);
    instr_t t;
    t.pc = pc; t.pc_next = pn; t.res = res;
    t.rd = rd; t.ca = ca; t.fl = fl;
    return t;
  endfunction

  task automatic model_reset();
    csr_m.delete();
    csr_m[32'h300] = 32'h0000_1800;
    csr_m[32'h305] = 32'd0;
    csr_m[32'h341] = 32'd0;
    csr_m[32'h342] = 32'd0;
  endtask

  function automatic logic [31:0] csr_rd(logic [11:0] a);
    if (csr_m.exists(int'(a))) return csr_m[int'(a)];
    return 32'd0;
  endfunction

  // Reference: spec rules applied to one instruction, then CSR update.
  task automatic model(input instr_t in, output logic [31:0] npc,
      output logic wen, output logic [31:0] wdata);
    logic [31:0] pc4;
    pc4 = in.pc + 32'd4;
    wen = in.fl[6] && (in.rd != 0);
    if (in.fl[3] || in.fl[2]) wdata = pc4;
    else if (in.fl[5])        wdata = csr_rd(in.ca);
    else                      wdata = in.res;
    if (in.fl[0])      npc = csr_m[32'h305];
    else if (in.fl[1]) npc = csr_m[32'h341];
    else if (in.fl[2]) npc = {in.res[31:1], 1'b0};
    else if (in.fl[3]) npc = in.pc_next;
    else if (in.fl[4]) npc = in.pc_next;
    else               npc = pc4;
    if (in.fl[0]) begin
      csr_m[32'h341] = in.pc;
      csr_m[32'h342] = 32'd11;
    end else if (in.fl[5] && csr_m.exists(int'(in.ca))) begin
      csr_m[int'(in.ca)] = in.res;
    end
  endtask

  task automatic drive(instr_t in);
    i_pc = in.pc; i_pc_next = in.pc_next; i_res = in.res;
    i_rd_addr = in.rd; i_csr_addr = in.ca;
    {i_wen, i_csr_wen, i_brch, i_jal, i_jalr, i_mret, i_ecall} = in.fl;
  endtask

  task automatic run(string tag, instr_t in, int stall,
      logic [31:0] e_npc, logic e_wen, logic [31:0] e_wd);
    int strobes;
    logic [4:0]  wa;
    logic [31:0] wd;
    strobes = 0; wa = '0; wd = '0;
    @(negedge clock);
    chk({tag, ".ready"}, 32'(o_ready), 32'd1);
    drive(in);
    i_valid = 1'b1;
    i_npc_ready = 1'b0;
    @(posedge clock);
    #1;
    // Keep valid high with junk: must be ignored outside IDLE.
    drive(mk($urandom, $urandom, $urandom, 5'($urandom),
             12'($urandom), 7'($urandom)));
    for (int k = 0; k <= stall; k++) begin
      @(negedge clock);
      i_npc_ready = (k == stall);
      if (k == stall) i_valid = 1'b0;
      #1;
      chk({tag, ".npc_valid"}, 32'(o_npc_valid), 32'd1);
      chk({tag, ".npc"}, o_npc, e_npc);
      chk({tag, ".retire"}, 32'(o_retire), 32'(k == stall));
      if (o_rf_wen) begin
        strobes++; wa = o_rf_waddr; wd = o_rf_wdata;
      end
    end
    chk({tag, ".strobes"}, 32'(strobes), 32'(e_wen));
    if (e_wen) begin
      chk({tag, ".waddr"}, 32'(wa), 32'(in.rd));
      chk({tag, ".wdata"}, wd, e_wd);
    end
    @(posedge clock);
    #1;
    i_npc_ready = 1'b0;
    chk({tag, ".idle"}, 32'({o_ready, o_npc_valid}), 32'b10);
  endtask

  task automatic csr_chk(string tag, logic [11:0] a, logic [31:0] e);
    i_csr_raddr = a;
    #1;
    chk(tag, o_csr_rdata, e);
  endtask

  vec_t vt[15];
  logic [31:0] m_npc, m_wd;
  logic        m_wen;

  initial begin
    vt[0]  = '{mk(32'h80000000, 0, 32'h1234, 5, 0, W),
               0, 32'h80000004, 1, 32'h1234};
    vt[1]  = '{mk(32'h80000004, 0, 32'h80002000, 7, 12'h305, W|C),
               3, 32'h80000008, 1, 32'h0};
    vt[2]  = '{mk(32'h80000008, 0, 32'h80001000, 8, 12'h305, W|C),
               1, 32'h8000000C, 1, 32'h80002000};
    vt[3]  = '{mk(32'h80000010, 0, 0, 0, 0, E),
               0, 32'h80001000, 0, 32'h0};
    vt[4]  = '{mk(32'h80000014, 0, 32'h80000014, 9, 12'h341, W|C),
               0, 32'h80000018, 1, 32'h80000010};
    vt[5]  = '{mk(32'h80000018, 0, 0, 0, 0, M),
               0, 32'h80000014, 0, 32'h0};
    vt[6]  = '{mk(32'h80000020, 0, 32'h80000101, 0, 0, W|JR),
               0, 32'h80000100, 0, 32'h0};
    vt[7]  = '{mk(32'h80000030, 32'h80000400, 0, 1, 0, W|J),
               2, 32'h80000400, 1, 32'h80000034};
    vt[8]  = '{mk(32'h80000040, 32'h80000010, 0, 0, 0, B),
               0, 32'h80000010, 0, 32'h0};
    vt[9]  = '{mk(32'hFFFFFFFC, 0, 7, 2, 0, W),
               0, 32'h0, 1, 32'h7};
    vt[10] = '{mk(32'hFFFFFFFC, 32'h100, 0, 3, 0, W|J),
               1, 32'h100, 1, 32'h0};
    vt[11] = '{mk(32'h80000050, 0, 5, 4, 12'h123, W|C),
               0, 32'h80000054, 1, 32'h0};
    vt[12] = '{mk(32'h80000060, 0, 32'h11111111, 0, 12'h341, C|E),
               0, 32'h80001000, 0, 32'h0};
    vt[13] = '{mk(32'h80000070, 32'h80000300, 32'h80000200, 6, 0,
               W|J|JR), 0, 32'h80000200, 1, 32'h80000074};
    vt[14] = '{mk(32'h80000080, 0, 0, 0, 0, M|E),
               0, 32'h80001000, 0, 32'h0};

    model_reset();
    #12;
    chk("rst.ready", 32'(o_ready), 32'd1);
    chk("rst.outs", {o_rf_wen, o_npc_valid, o_retire, o_rf_waddr},
        32'd0);
    chk("rst.wdata", o_rf_wdata, 32'd0);
    chk("rst.npc", o_npc, 32'd0);
    csr_chk("rst.mstatus", 12'h300, 32'h1800);
    csr_chk("rst.mtvec", 12'h305, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vt[i]) begin
      model(vt[i].in, m_npc, m_wen, m_wd);
      run($sformatf("vec%0d", i), vt[i].in, vt[i].stall,
          vt[i].npc, vt[i].wen, vt[i].wdata);
    end
    csr_chk("dir.mtvec", 12'h305, 32'h80001000);
    csr_chk("dir.mepc", 12'h341, 32'h80000080);
    csr_chk("dir.mcause", 12'h342, 32'd11);
    csr_chk("dir.unimpl", 12'h123, 32'd0);

    for (int n = 0; n < 200; n++) begin
      instr_t r;
      int sel;
      logic [11:0] cas [5];
      cas = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
      r = mk($urandom & ~32'd3, $urandom & ~32'd3, $urandom,
             5'($urandom), cas[$urandom_range(0, 4)], 7'd0);
      sel = $urandom_range(0, 7);
      case (sel)
        0: r.fl = W;
        1: r.fl = B | ($urandom_range(0, 1) ? W : 7'd0);
        2: r.fl = W | J;
        3: r.fl = W | JR;
        4: r.fl = M;
        5: r.fl = E;
        6: r.fl = W | C;
        default: r.fl = 7'($urandom);
      endcase
      model(r, m_npc, m_wen, m_wd);
      run($sformatf("rnd%0d", n), r, $urandom_range(0, 3),
          m_npc, m_wen, m_wd);
      csr_chk("rnd.csr", r.ca, csr_rd(r.ca));
    end
    csr_chk("end.mstatus", 12'h300, csr_rd(12'h300));
    csr_chk("end.mtvec", 12'h305, csr_rd(12'h305));
    csr_chk("end.mepc", 12'h341, csr_rd(12'h341));
    csr_chk("end.mcause", 12'h342, csr_rd(12'h342));

    // Reset in the middle of WAIT.
    @(negedge clock);
    drive(mk(32'h80000100, 0, 32'hDEADBEEF, 0, 12'h300, C));
    i_valid = 1'b1;
    i_npc_ready = 1'b0;
    @(posedge clock);
    #1;
    i_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("wait.npc_valid", 32'(o_npc_valid), 32'd1);
    csr_chk("wait.mstatus", 12'h300, 32'hDEADBEEF);
    i_npc_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("arst.npc_valid", 32'(o_npc_valid), 32'd0);
    chk("arst.ready", 32'(o_ready), 32'd1);
    chk("arst.retire", 32'(o_retire), 32'd0);
    chk("arst.npc", o_npc, 32'd0);
    csr_chk("arst.mstatus", 12'h300, 32'h1800);
    @(negedge clock);
    reset = 1'b0;
    i_npc_ready = 1'b0;
    model_reset();
    r_after: begin
      instr_t t;
      t = mk(32'h80000000, 0, 32'h55, 10, 0, W);
      model(t, m_npc, m_wen, m_wd);
      run("post_rst", t, 1, m_npc, m_wen, m_wd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
